cardiac_sense_detector: RTL and testbench



---
 rtl/cardiac_sense_pkg.sv | 28 ++
 rtl/cardiac_sense_detector_sense_channel.sv | 120 ++++++++++++
 rtl/cardiac_sense_detector.sv | 122 ++++++++++++
 tb/tb_cardiac_sense_detector.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cardiac_sense_pkg.sv
// Shared definitions for the cardiac sense front end: channel state
// encoding, default sample width, polarity codes and the saturating negate.
package cardiac_sense_pkg;

  // Per-channel FSM encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_ARMED   = 2'd0;
  localparam logic [1:0] ST_QUALIFY = 2'd1;
  localparam logic [1:0] ST_SENSED  = 2'd2;
  localparam logic [1:0] ST_BLANK   = 2'd3;

  localparam int DEFAULT_ADC_W = 12;

  // Polarity select: positive deflection as-is, or negated.
  localparam logic POL_POS = 1'b0;
  localparam logic POL_NEG = 1'b1;

  // Negate a sign-extended sample of 'width' bits, clamping the single
  // overflow case (most negative code) to the most positive code.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x,
                                                 input int width);
    logic signed [31:0] max_pos;
    logic signed [31:0] neg;
    max_pos = (32'sd1 <<< (width - 1)) - 32'sd1;
    neg     = -x;
    return (neg > max_pos) ? max_pos : neg;
  endfunction

endpackage

// File: rtl/cardiac_sense_detector_sense_channel.sv
// One electrogram channel: polarity, threshold compare, debounce FSM,
// sense hold and post-event / post-pace blanking.
module sense_channel
  import cardiac_sense_pkg::*;
#(
  parameter int ADC_W        = DEFAULT_ADC_W,
  parameter int TH_SHIFT     = 6,
  parameter int DEBOUNCE     = 3,
  parameter int SENSE_HOLD   = 4,
  parameter int BLANK_CYCLES = 5_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic signed [ADC_W-1:0] sample,
  input  logic                    pol,
  input  logic [4:0]              th,
  input  logic                    pace,
  output logic                    sense,
  output logic signed [ADC_W-1:0] adj
);

  localparam int CNT_MAX = (BLANK_CYCLES > SENSE_HOLD) ? BLANK_CYCLES : SENSE_HOLD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int QW      = $clog2(DEBOUNCE + 1);

  logic [1:0]          state, state_d;
  logic [QW-1:0]       qcnt, qcnt_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic signed [31:0]  adj_wide;
  logic [ADC_W:0]      thr;
  logic                qualify;
  logic                unused_adj_hi;

  // The saturated result always fits back into ADC_W bits.
  assign adj_wide      = (pol == POL_NEG) ? sat_neg(32'(sample), ADC_W) : 32'(sample);
  assign adj           = adj_wide[ADC_W-1:0];
  assign unused_adj_hi = ^adj_wide[31:ADC_W];

  // Threshold zero-extended to ADC_W+1 bits; adj sign-extended to match.
  assign thr     = (ADC_W + 1)'(th) << TH_SHIFT;
  assign qualify = (th != 5'd0) && ($signed({adj[ADC_W-1], adj}) >= $signed(thr));

  // Next-state logic: pace overrides everything, otherwise walk the FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state;
    qcnt_d  = qcnt;
    cnt_d   = cnt;
    if (pace) begin
      // Held in BLANK with a full count until the pace input falls.
      state_d = ST_BLANK;
      qcnt_d  = '0;
      cnt_d   = CW'(BLANK_CYCLES);
    end else begin
      case (state)
        ST_ARMED: begin
          if (sample_valid && qualify) begin
            if (DEBOUNCE <= 1) begin
              state_d = ST_SENSED;
              cnt_d   = CW'(SENSE_HOLD - 1);
            end else begin
              state_d = ST_QUALIFY;
              qcnt_d  = QW'(1);
            end
          end
        end
        ST_QUALIFY: begin
          if (sample_valid) begin
            if (!qualify) begin
              state_d = ST_ARMED;
              qcnt_d  = '0;
            end else if (qcnt >= QW'(DEBOUNCE - 1)) begin
              state_d = ST_SENSED;
              qcnt_d  = '0;
              cnt_d   = CW'(SENSE_HOLD - 1);
            end else begin
              qcnt_d = qcnt + QW'(1);
            end
          end
        end
        ST_SENSED: begin
          // cnt runs SENSE_HOLD-1 .. 0, one cycle each.
          if (cnt == '0) begin
            state_d = ST_BLANK;
            cnt_d   = CW'(BLANK_CYCLES);
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
        default: begin
          // BLANK occupies exactly BLANK_CYCLES clocks (count N .. 1).
          if (cnt <= CW'(1)) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
      endcase
    end
  end

  // State, counters and the registered sense level.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (rst) begin
      state <= ST_ARMED;
      qcnt  <= '0;
      cnt   <= '0;
      sense <= 1'b0;
    end else begin
      state <= state_d;
      qcnt  <= qcnt_d;
      cnt   <= cnt_d;
      sense <= (state_d == ST_SENSED);
    end
  end

endmodule

// File: rtl/cardiac_sense_detector.sv
// Three-channel cardiac sense detector (atrium, RV, LV) with optional
// evoked-response capture check after each RV pace.
// Optional feature macro: SENSE_ER_EN (evoked-response window logic).
module cardiac_sense_detector
  import cardiac_sense_pkg::*;
#(
  parameter int ADC_W        = DEFAULT_ADC_W,
  parameter int TH_SHIFT     = 6,
  parameter int DEBOUNCE     = 3,
  parameter int SENSE_HOLD   = 4,
  parameter int BLANK_CYCLES = 5_000_000,
  parameter int ER_WINDOW    = 2_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic signed [ADC_W-1:0] sample_a,
  input  logic signed [ADC_W-1:0] sample_v,
  input  logic signed [ADC_W-1:0] sample_lv,
  input  logic                    pol_a,
  input  logic                    pol_v,
  input  logic                    pol_lv,
  input  logic [4:0]              th_a,
  input  logic [4:0]              th_v,
  input  logic [4:0]              th_lv,
  input  logic [4:0]              er_th,
  input  logic                    pace_a,
  input  logic                    pace_rv,
  input  logic                    pace_lv,
  output logic                    sense_a,
  output logic                    sense_v,
  output logic                    sense_lv,
  output logic                    er_capture,
  output logic                    er_loss
);

  logic signed [ADC_W-1:0] adj_a, adj_v, adj_lv;
  logic                    unused_adj;

  assign unused_adj = ^{adj_a, adj_lv};

  sense_channel #(
    .ADC_W(ADC_W), .TH_SHIFT(TH_SHIFT), .DEBOUNCE(DEBOUNCE),
    .SENSE_HOLD(SENSE_HOLD), .BLANK_CYCLES(BLANK_CYCLES)
  ) u_ch_a (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample_a),
    .pol(pol_a), .th(th_a), .pace(pace_a), .sense(sense_a), .adj(adj_a)
  );

  sense_channel #(
    .ADC_W(ADC_W), .TH_SHIFT(TH_SHIFT), .DEBOUNCE(DEBOUNCE),
    .SENSE_HOLD(SENSE_HOLD), .BLANK_CYCLES(BLANK_CYCLES)
  ) u_ch_v (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample_v),
    .pol(pol_v), .th(th_v), .pace(pace_rv), .sense(sense_v), .adj(adj_v)
  );

  sense_channel #(
    .ADC_W(ADC_W), .TH_SHIFT(TH_SHIFT), .DEBOUNCE(DEBOUNCE),
    .SENSE_HOLD(SENSE_HOLD), .BLANK_CYCLES(BLANK_CYCLES)
  ) u_ch_lv (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample_lv),
    .pol(pol_lv), .th(th_lv), .pace(pace_lv), .sense(sense_lv), .adj(adj_lv)
  );

`ifdef SENSE_ER_EN
  localparam int EW = $clog2(ER_WINDOW + 1);

  logic           pace_rv_q;
  logic           er_open;
  logic [EW-1:0]  er_cnt;
  logic [ADC_W:0] er_thr;
  logic           er_hit;

  // ER compare taps the polarity-adjusted V sample and ignores V blanking.
  assign er_thr = (ADC_W + 1)'(er_th) << TH_SHIFT;
  assign er_hit = sample_valid && ($signed({adj_v[ADC_W-1], adj_v}) >= $signed(er_thr));

  // Window opens at the edge that sees pace_rv fall and then covers the
  // following ER_WINDOW cycles; verdict pulses are registered and exclusive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pace_rv_q  <= 1'b0;
      er_open    <= 1'b0;
      er_cnt     <= '0;
      er_capture <= 1'b0;
      er_loss    <= 1'b0;
    end else begin
      pace_rv_q  <= pace_rv;
      er_capture <= 1'b0;
      er_loss    <= 1'b0;
      if (pace_rv && !pace_rv_q) begin
        er_open <= 1'b0;
        er_cnt  <= '0;
      end else if (!pace_rv && pace_rv_q) begin
        er_open <= 1'b1;
        er_cnt  <= EW'(ER_WINDOW);
      end else if (er_open) begin
        if (er_hit) begin
          er_capture <= 1'b1;
          er_open    <= 1'b0;
          er_cnt     <= '0;
        end else if (er_cnt <= EW'(1)) begin
          er_loss <= 1'b1;
          er_open <= 1'b0;
          er_cnt  <= '0;
        end else begin
          er_cnt <= er_cnt - EW'(1);
        end
      end
    end
  end
`else
  localparam int unused_er_window = ER_WINDOW;
  logic unused_er;

  assign unused_er  = ^{er_th, adj_v};
  assign er_capture = 1'b0;
  assign er_loss    = 1'b0;
`endif

endmodule

// File: tb/tb_cardiac_sense_detector.sv
// Directed self-checking bench for cardiac_sense_detector
// (BLANK_CYCLES=20, ER_WINDOW=10, DEBOUNCE=3, SENSE_HOLD=4, threshold 15 -> 960).
module tb_cardiac_sense_detector;

`ifdef SENSE_ER_EN
  localparam logic ER_ON = 1'b1;
`else
  localparam logic ER_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_valid;
  logic signed [11:0] sample_a, sample_v, sample_lv;
  logic              pol_a, pol_v, pol_lv;
  logic [4:0]        th_a, th_v, th_lv, er_th;
  logic              pace_a, pace_rv, pace_lv;
  logic              sense_a, sense_v, sense_lv, er_capture, er_loss;

  int n_checks = 0;
  int n_fail   = 0;
  logic seen;

  cardiac_sense_detector #(
    .ADC_W(12), .TH_SHIFT(6), .DEBOUNCE(3), .SENSE_HOLD(4),
    .BLANK_CYCLES(20), .ER_WINDOW(10)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid),
    .sample_a(sample_a), .sample_v(sample_v), .sample_lv(sample_lv),
    .pol_a(pol_a), .pol_v(pol_v), .pol_lv(pol_lv),
    .th_a(th_a), .th_v(th_v), .th_lv(th_lv), .er_th(er_th),
    .pace_a(pace_a), .pace_rv(pace_rv), .pace_lv(pace_lv),
    .sense_a(sense_a), .sense_v(sense_v), .sense_lv(sense_lv),
    .er_capture(er_capture), .er_loss(er_loss)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid sample on all three channels for exactly one cycle.
  task automatic drive(input logic signed [11:0] a, v, lv);
    sample_a     = a;
    sample_v     = v;
    sample_lv    = lv;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sample_valid = 1'b0;
    sample_a = '0; sample_v = '0; sample_lv = '0;
    pol_a = 1'b0; pol_v = 1'b0; pol_lv = 1'b0;
    th_a = 5'd15; th_v = 5'd15; th_lv = 5'd0; er_th = 5'd10;
    pace_a = 1'b0; pace_rv = 1'b0; pace_lv = 1'b0;

    // Reset state
    #1;
    check("rst sense_a", sense_a, 1'b0);
    check("rst sense_v", sense_v, 1'b0);
    check("rst sense_lv", sense_lv, 1'b0);
    check("rst er_capture", er_capture, 1'b0);
    check("rst er_loss", er_loss, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: three samples of 1000 -> 4-cycle sense, then 20 blanked cycles
    drive(0, 1000, 0);  check("t1 s1", sense_v, 1'b0);
    drive(0, 1000, 0);  check("t1 s2", sense_v, 1'b0);
    drive(0, 1000, 0);  check("t1 rise", sense_v, 1'b1);
    tick();             check("t1 hold2", sense_v, 1'b1);
    tick();             check("t1 hold3", sense_v, 1'b1);
    tick();             check("t1 hold4", sense_v, 1'b1);
    tick();             check("t1 fall", sense_v, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 2000, 0);
      seen |= sense_v;
    end
    check("t1 blanked", seen, 1'b0);
    // Blanking has just ended: a fresh full debounce is needed
    drive(0, 1000, 0);  check("t1 post q1", sense_v, 1'b0);
    drive(0, 1000, 0);  check("t1 post q2", sense_v, 1'b0);
    drive(0, 1000, 0);  check("t1 post sense", sense_v, 1'b1);
    repeat (30) tick();

    // 2: a sub-threshold sample breaks the debounce run
    drive(0, 1000, 0);
    drive(0, 1000, 0);
    drive(0, 500, 0);   check("t2 break", sense_v, 1'b0);
    drive(0, 1000, 0);  check("t2 restart1", sense_v, 1'b0);
    drive(0, 1000, 0);  check("t2 restart2", sense_v, 1'b0);
    drive(0, 1000, 0);  check("t2 sense", sense_v, 1'b1);
    repeat (30) tick();

    // 3: negated polarity on the atrium, including saturation of -2048
    pol_a = 1'b1;
    drive(-1000, 0, 0);
    drive(-1000, 0, 0);
    drive(-1000, 0, 0); check("t3 neg sense", sense_a, 1'b1);
    repeat (30) tick();
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1000, 0, 0);
      seen |= sense_a;
    end
    check("t3 wrong pol", seen, 1'b0);
    th_a = 5'd31;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(-1983, 0, 0);
      seen |= sense_a;
    end
    check("t3 below 1984", seen, 1'b0);
    drive(-2048, 0, 0);
    drive(-2048, 0, 0);
    drive(-2048, 0, 0); check("t3 sat sense", sense_a, 1'b1);
    repeat (30) tick();

    // 4: threshold 0 disables LV
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 2047);
      seen |= sense_lv;
    end
    check("t4 lv disabled", seen, 1'b0);

    // 5a: pace truncates an active sense and blanks the V channel
    drive(0, 1000, 0);
    drive(0, 1000, 0);
    drive(0, 1000, 0);  check("t5 pre-pace sense", sense_v, 1'b1);
    pace_rv = 1'b1;
    drive(0, 1000, 0);  check("t5 truncate", sense_v, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1000, 0);
      seen |= sense_v;
    end
    pace_rv = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(0, 1000, 0);
      seen |= sense_v;
    end
    check("t5 pace blank", seen, 1'b0);
    repeat (30) tick();

    // 5b: evoked response above er_th in the window -> capture pulse
    sample_v = '0;
    pace_rv = 1'b1;
    repeat (5) tick();
    pace_rv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= er_capture | er_loss;
    end
    check("t5 er quiet", seen, 1'b0);
    drive(0, 700, 0);
    check("t5 capture", er_capture, ER_ON);
    check("t5 capture no loss", er_loss, 1'b0);
    tick();
    check("t5 capture 1cyc", er_capture, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen |= er_capture | er_loss;
    end
    check("t5 window closed", seen, 1'b0);

    // 5c: no response -> loss pulse when the window expires
    pace_rv = 1'b1;
    repeat (5) tick();
    pace_rv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0);
      seen |= er_capture | er_loss;
    end
    check("t5 loss early", seen, 1'b0);
    drive(0, 0, 0);
    check("t5 loss", er_loss, ER_ON);
    check("t5 loss no capture", er_capture, 1'b0);
    tick();
    check("t5 loss 1cyc", er_loss, 1'b0);
    repeat (30) tick();

    // 6: reset in QUALIFY and in SENSED
    drive(0, 1000, 0);
    drive(0, 1000, 0);
    rst = 1'b1;
    #2;
    check("t6 rst qualify", sense_v, 1'b0);
    tick();
    rst = 1'b0;
    drive(0, 1000, 0);  check("t6 fresh1", sense_v, 1'b0);
    drive(0, 1000, 0);  check("t6 fresh2", sense_v, 1'b0);
    drive(0, 1000, 0);  check("t6 fresh3", sense_v, 1'b1);
    tick();             check("t6 sensed", sense_v, 1'b1);
    rst = 1'b1;
    #2;
    check("t6 rst async", sense_v, 1'b0);
    tick();
    rst = 1'b0;
    drive(0, 1000, 0);
    drive(0, 1000, 0);  check("t6 armed q2", sense_v, 1'b0);
    drive(0, 1000, 0);  check("t6 armed sense", sense_v, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
